// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display.
// Optional signed mode is selected with the CALC_SIGNED_EN macro.
package calc_pkg;

  localparam int unsigned RESUL_W = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SR_W    = BCD_W + RESUL_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble nibble correction applied before each shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder with blanking.
// Segment order {g,f,e,d,c,b,a}, active-high.
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_result_display.sv
// Accepts calculator results, converts to BCD by double-dabble and scans a 4-digit display.
// Define CALC_SIGNED_EN to treat resul as two's complement and show a minus on digit 3.
module calc_result_display
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               resul_valid,
  input  logic [RESUL_W-1:0] resul,
  output logic               resul_ready,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid,
  output logic [6:0]         seg,
  output logic [3:0]         an
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d, sr_adj;
  logic [2:0]         iter_q, iter_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic [ScanW-1:0]   scan_q;
  logic [1:0]         idx_q;
  logic [RESUL_W-1:0] mag;
  logic [6:0]         sign_seg, dec_seg;
  logic [3:0]         dec_digit;
  logic               dec_blank;

`ifdef CALC_SIGNED_EN
  logic neg_pend_q, neg_q;

  assign mag      = resul[RESUL_W-1] ? (~resul + 8'd1) : resul;
  assign sign_seg = neg_q ? SEG_MINUS : SEG_BLANK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && resul_valid) neg_pend_q <= resul[RESUL_W-1];
      if (state_q == DONE)                neg_q      <= neg_pend_q;
    end
  end
`else
  assign mag      = resul;
  assign sign_seg = SEG_BLANK;
`endif

  assign sr_adj = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (resul_valid) begin
          sr_d    = {{BCD_W{1'b0}}, mag};
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        // bcd_q doubles as the display register; it only moves here, so the scan never tears.
        bcd_d       = sr_q[SR_W-1 -: BCD_W];
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + ScanW'(1);
    end
  end

  always_comb begin
    dec_digit = bcd_q[3:0];
    dec_blank = 1'b0;
    unique case (idx_q)
      2'd0: begin
        dec_digit = bcd_q[3:0];
        dec_blank = 1'b0;
      end
      2'd1: begin
        dec_digit = bcd_q[7:4];
        dec_blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        dec_digit = bcd_q[11:8];
        dec_blank = (bcd_q[11:8] == 4'd0);
      end
      2'd3: begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit_i (dec_digit),
    .blank_i (dec_blank),
    .seg_o   (dec_seg)
  );

  assign resul_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign bcd         = bcd_q;
  assign bcd_valid   = bcd_valid_q;
  assign an          = 4'b0001 << idx_q;
  assign seg         = (idx_q == 2'd3) ? sign_seg : dec_seg;

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboarded random and directed bench for calc_result_display.
// Honours CALC_SIGNED_EN the same way as the design.
module tb_calc_result_display;

  localparam int unsigned SCAN_DIV = 3;

  logic        clk;
  logic        rst;
  logic        resul_valid;
  logic [7:0]  resul;
  logic        resul_ready;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  calc_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .resul_valid (resul_valid),
    .resul       (resul),
    .resul_ready (resul_ready),
    .busy        (busy),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .seg         (seg),
    .an          (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit neg;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: cycles since reset, last accept, what the display shows.
  int cyc      = 0;
  int acc_cyc  = -1;
  int pend_val = 0;
  bit pend_neg = 1'b0;
  int disp_val = 0;
  bit disp_neg = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int v, input bit neg);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (idx)
      0:       return seg_tab[u];
      1:       return (h == 0 && t == 0) ? 7'h00 : seg_tab[t];
      2:       return (h == 0) ? 7'h00 : seg_tab[h];
      default: return neg ? 7'h40 : 7'h00;
    endcase
  endfunction

  function automatic bit m_ready();
    return (acc_cyc < 0) || (cyc - acc_cyc >= 9);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      = 0;
      acc_cyc  = -1;
      disp_val = 0;
      disp_neg = 1'b0;
      exp_q.delete();
    end else begin
      if (acc_cyc >= 0 && cyc + 1 == acc_cyc + 9) begin
        disp_val = pend_val;
        disp_neg = pend_neg;
      end
      if (resul_valid && m_ready()) begin
        exp_t e;
`ifdef CALC_SIGNED_EN
        e.val = resul[7] ? 256 - int'(resul) : int'(resul);
        e.neg = resul[7];
`else
        e.val = int'(resul);
        e.neg = 1'b0;
`endif
        e.acc    = cyc + 1;
        pend_val = e.val;
        pend_neg = e.neg;
        acc_cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int idx;
      idx = (cyc / int'(SCAN_DIV)) % 4;
      if (bcd_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_bcd_valid: got bcd %0h expected no pulse", bcd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bcd_on_valid", 32'(bcd), 32'(to_bcd(e.val)));
          chk("bcd_latency", 32'(cyc), 32'(e.acc + 9));
        end
      end
      chk("resul_ready", 32'(resul_ready), 32'(m_ready()));
      chk("busy", 32'(busy), 32'(!m_ready()));
      chk("bcd_held", 32'(bcd), 32'(to_bcd(disp_val)));
      chk("an", 32'(an), 32'(4'b0001 << idx));
      chk("seg", 32'(seg), 32'(exp_seg(idx, disp_val, disp_neg)));
    end
  end

  task automatic send(input logic [7:0] v);
    resul       = v;
    resul_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (resul_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got no accept for %0h expected accept within 40 cycles", v);
  endtask

  task automatic idle(input int n);
    resul_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'h1);
    chk({tag, "_seg"}, 32'(seg), 32'h3F);
    chk({tag, "_bcd"}, 32'(bcd), 32'h0);
    chk({tag, "_ready"}, 32'(resul_ready), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_bcd_valid"}, 32'(bcd_valid), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    resul_valid = 1'b0;
    resul       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    send(8'd255);
    idle(16);
    send(8'd7);
    idle(16);
    // Valid held across both transfers; the second waits for resul_ready.
    send(8'd100);
    send(8'd42);
    idle(24);
    send(8'hFD);
    idle(16);
    send(8'h80);
    idle(16);

    // Reset lands in the 4th SHIFT cycle of 200.
    send(8'd200);
    resul_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(14);
    send(8'd200);
    idle(16);

    for (int k = 0; k < 40; k++) begin
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
    end
    idle(24);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
